// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM core. It steps the shared memory/ALU
// datapath through fetch/decode/execute/writeback. Optional wait-state support is enabled by MULTICYCLE_MEM_WAIT_EN.
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] SRCA_RD1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_OUT   = 2'b00;
    localparam logic [1:0] RES_DATA  = 2'b01;
    localparam logic [1:0] RES_ALU   = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_ok;
    logic   unused_inputs;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok        = mem_ready;
    assign unused_inputs = ^Funct[4:1];
`else
    // The wait input stays on the port list, so the interface does not change with the build.
    assign mem_ok        = 1'b1;
    assign unused_inputs = ^{Funct[4:1], mem_ready};
`endif

    // NOTE: sequential state uses non-blocking assignments. All flops then update
    // together on the edge, and the order of evaluation does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default before the case. A path that
    // does not assign it then cannot infer a latch.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = mem_ok ? MEMWB : MEMRD;
            MEMWR:  state_next = mem_ok ? FETCH : MEMWR;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            MEMWB:  state_next = FETCH;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ok;
                ctrl.next_pc    = mem_ok;
            end
            DECODE: begin
                // PC+4 is computed again here, so R15 reads as PC+8.
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.illegal_op = (Op == 2'b11);
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.adr_src = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // The strobe is held for the whole wait. Completion is flagged only on the ready cycle.
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
                ctrl.instr_done = mem_ok;
            end
            EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = 1'b1;
            end
            EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_OUT;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Strobes are cut at once by reset. A write in flight never leaks a partial pulse.
    always_comb begin
        IRWrite    = ctrl.ir_write   & rst_n;
        NextPC     = ctrl.next_pc    & rst_n;
        RegW       = ctrl.reg_w      & rst_n;
        MemW       = ctrl.mem_w      & rst_n;
        Branch     = ctrl.branch     & rst_n;
        instr_done = ctrl.instr_done & rst_n;
        illegal_op = ctrl.illegal_op & rst_n;
    end

    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. Expected per-cycle traces come from
// instruction classes and the per-state output table.
module tb_multicycle_main_fsm;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, instr_done, illegal_op;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state_o;

    multicycle_main_fsm dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .instr_done(instr_done),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Layout: {state, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, instr_done, illegal_op}
    logic [18:0] act_vec;
    assign act_vec = {state_o, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                      ALUOp, RegW, MemW, Branch, instr_done, illegal_op};

    logic [18:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                     name, $time, act[18:15], act[14:0], exp[18:15], exp[14:0]);
        end
    endtask

    // Expected outputs for one cycle in state st. They follow the per-state output table.
    function automatic logic [18:0] model(input int st, input logic [1:0] op, input logic rdy, input logic rn);
        logic r, ir, np, adr, aluop, rw, mw, br, done, ill;
        logic [1:0] sa, sb, res;
        r = WAIT_EN ? rdy : 1'b1;
        ir = 0; np = 0; adr = 0; aluop = 0; rw = 0; mw = 0; br = 0; done = 0; ill = 0;
        sa = 2'b00; sb = 2'b00; res = 2'b00;
        case (st)
            0: begin sa = 2'b01; sb = 2'b10; res = 2'b10; ir = r; np = r; end
            1: begin sa = 2'b01; sb = 2'b10; res = 2'b10; ill = (op == 2'b11); end
            2: begin sb = 2'b01; end
            3: begin adr = 1; end
            4: begin res = 2'b01; rw = 1; done = 1; end
            5: begin adr = 1; mw = 1; done = r; end
            6: begin aluop = 1; end
            7: begin sb = 2'b01; aluop = 1; end
            8: begin rw = 1; done = 1; end
            9: begin sb = 2'b01; res = 2'b10; br = 1; done = 1; end
            default: ;
        endcase
        if (!rn) begin
            ir = 0; np = 0; rw = 0; mw = 0; br = 0; done = 0; ill = 0;
        end
        return {st[3:0], ir, np, adr, sa, sb, res, aluop, rw, mw, br, done, ill};
    endfunction

    // Monitor: it compares each cycle's outputs against the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle", act_vec, exp_q.pop_front());
        end
    end

    task automatic step(input logic [1:0] op, input logic [5:0] funct, input logic rdy,
                        input logic rn, input int st);
        @(posedge clk);
        #1;
        Op = op; Funct = funct; mem_ready = rdy; rst_n = rn;
        exp_q.push_back(model(st, op, rdy, rn));
    endtask

    // An instruction class picks its state path. FETCH, MEMRD and MEMWR repeat while memory stalls.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input int rst_at,
                             input int memwr_waits, input bit rnd_ready);
        int path[$];
        int waits;
        logic rdy;
        waits = memwr_waits;
        case (op)
            2'b00: path = funct[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            2'b01: path = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10: path = '{0, 1, 9};
            default: path = '{0, 1};
        endcase
        foreach (path[i]) begin
            do begin
                rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (path[i] == 5 && waits > 0) begin
                    rdy = 1'b0;
                    waits--;
                end
                step(op, funct, rdy, 1'b1, path[i]);
            end while (WAIT_EN && (path[i] == 0 || path[i] == 3 || path[i] == 5) && !rdy);
            if (i == rst_at) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
                #1 check("async_reset", act_vec, model(0, op, rdy, 1'b0));
                step(op, funct, 1'b1, 1'b0, 0);
                return;
            end
        end
    endtask

    initial begin
        Op = 2'b00; Funct = 6'd0; mem_ready = 1'b1; rst_n = 1'b0;
        repeat (3) step(2'b00, 6'd0, 1'b1, 1'b0, 0);

        run_instr(2'b00, 6'b101000, -1, 0, 1'b0);
        run_instr(2'b00, 6'b001000, -1, 0, 1'b0);
        run_instr(2'b01, 6'b011001, -1, 0, 1'b0);
        run_instr(2'b01, 6'b011000, -1, 2, 1'b0);
        run_instr(2'b10, 6'b110101, -1, 0, 1'b0);
        run_instr(2'b11, 6'b000000, -1, 0, 1'b0);
        run_instr(2'b01, 6'b011001, 4, 0, 1'b0);
        run_instr(2'b00, 6'b101000, -1, 0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            logic [1:0] op;
            logic [5:0] funct;
            int rst_at;
            op     = 2'($urandom_range(0, 3));
            funct  = 6'($urandom);
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, funct, rst_at, int'($urandom_range(0, 2)), 1'b1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
